// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_e;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the two-port memory arbiter
// slave: arbiter view (takes requests and mem_rdata, drives grants, read returns, memory strobes)
// master: requesters plus memory view
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_rd, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port memory arbiter with burst lock, round-robin tie-break and burst limit
// clk: rising-edge clock; rst: asynchronous active-low reset; bus: requester and memory signals
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 8
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST);
  localparam logic [CW-1:0] LAST  = CW'(MAX_BURST - 1);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_owner_q, rvalid0_q, rvalid1_q;
  logic          owned, owner, cur_req, cur_we, other_req, access, release_now;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  always_comb begin
    owned       = state_q != IDLE;
    owner       = (state_q == OWN1) ? P1 : P0;
    cur_req     = (owner == P1) ? bus.req1 : bus.req0;
    cur_we      = (owner == P1) ? bus.we1 : bus.we0;
    other_req   = (owner == P1) ? bus.req0 : bus.req1;
    // a saturated burst facing a waiting peer gives up the cycle without accessing
    access      = owned & cur_req & ~(other_req & (cnt_q == LIMIT));
    // release also on the access that reaches the limit, so the peer sees only one dead cycle
    release_now = owned & (~cur_req | (other_req & (cnt_q >= LAST)));
    addr_mux    = ~owned ? '0 : (owner == P1) ? bus.addr1 : bus.addr0;
    wdata_mux   = ~owned ? '0 : (owner == P1) ? bus.wdata1 : bus.wdata0;
  end
  assign bus.mem_rd    = access & ~cur_we;
  assign bus.mem_wr    = access & cur_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.gnt0      = state_q == OWN0;
  assign bus.gnt1      = state_q == OWN1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= P1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      // the read tag travels with the strobe, so a read on the final grant cycle still returns to its issuer
      rvalid0_q <= bus.mem_rd & (owner == P0);
      rvalid1_q <= bus.mem_rd & (owner == P1);
      if (state_q == IDLE) begin
        if (bus.req0 & (~bus.req1 | (last_owner_q == P1))) begin
          state_q      <= OWN0;
          cnt_q        <= '0;
          last_owner_q <= P0;
        end else if (bus.req1) begin
          state_q      <= OWN1;
          cnt_q        <= '0;
          last_owner_q <= P1;
        end
      end else if (release_now) begin
        state_q <= IDLE;
      end else if (cnt_q != LIMIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench with a read-return scoreboard
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  typedef struct {
    logic       port;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_asserts = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mem_m [16];
  mem_arbiter_if #(.AW(4), .DW(8)) bus ();
  mem_arbiter #(.AW(4), .DW(8), .MAX_BURST(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_wr) mem_m[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem_m[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (bus.rvalid0 | bus.rvalid1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
      else begin
        mon_e = exp_q.pop_front();
        chk("sb_port", {bus.rvalid1, bus.rvalid0}, mon_e.port ? 2'b10 : 2'b01);
        chk("sb_data", bus.rvalid1 ? bus.rdata1 : bus.rdata0, mon_e.data);
      end
    end
  end
  initial begin
    foreach (mem_m[k]) mem_m[k] = 8'h00;
    bus.mem_rdata = 8'h00;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    chk("rst_strobes", {bus.mem_rd, bus.mem_wr}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    @(negedge clk);
    rst = 1; bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
    #1;
    chk("lat_gnt0", bus.gnt0, 0);
    chk("lat_no_wr", bus.mem_wr, 0);
    @(negedge clk);
    #1;
    chk("wr_gnt0", bus.gnt0, 1);
    chk("wr_strobe", {bus.mem_rd, bus.mem_wr}, 2'b01);
    chk("wr_addr", bus.mem_addr, 3);
    chk("wr_data", bus.mem_wdata, 8'hA5);
    @(negedge clk);
    bus.we0 = 0;
    exp_q.push_back('{P0, 8'hA5});
    #1;
    chk("rd_strobe", {bus.mem_rd, bus.mem_wr}, 2'b10);
    chk("rd_addr", bus.mem_addr, 3);
    @(negedge clk);
    bus.req0 = 0;
    #1;
    chk("rd_rvalid0", bus.rvalid0, 1);
    chk("rd_rdata0", bus.rdata0, 8'hA5);
    chk("rd_rvalid1", bus.rvalid1, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1; bus.req0 = 1; bus.req1 = 1; bus.we0 = 1; bus.we1 = 1; bus.addr1 = 4'd14; bus.wdata1 = 8'h3C;
    @(negedge clk);
    #1;
    chk("tie_gnt0", bus.gnt0, 1);
    chk("tie_gnt1", bus.gnt1, 0);
    bus.req0 = 0;
    @(negedge clk);
    #1;
    chk("gap_gnts", {bus.gnt1, bus.gnt0}, 2'b00);
    @(negedge clk);
    #1;
    chk("rr_gnt1", {bus.gnt1, bus.gnt0}, 2'b10);
    chk("p1_wr_addr", bus.mem_addr, 14);
    chk("p1_wr_data", bus.mem_wdata, 8'h3C);
    @(negedge clk);
    bus.req1 = 0;
    @(negedge clk);
    bus.req0 = 1; bus.req1 = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.we0 = (i != 7);
      bus.addr0 = (i == 7) ? 4'd5 : 4'(i);
      bus.wdata0 = 8'h10 + 8'(i);
      bus.we1 = 1'(i & 1);
      bus.addr1 = 4'(15 - i);
      bus.wdata1 = ~8'(i);
      if (i == 7) exp_q.push_back('{P0, 8'h15});
      #1;
      chk("burst_gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
      chk("burst_strobe", {bus.mem_rd, bus.mem_wr}, (i == 7) ? 2'b10 : 2'b01);
      chk("iso_addr", bus.mem_addr, (i == 7) ? 5 : i);
      if (i != 7) chk("iso_wdata", bus.mem_wdata, 8'h10 + 8'(i));
      @(negedge clk);
    end
    bus.we1 = 1; bus.addr1 = 4'd8;
    #1;
    chk("rel_gnts", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rel_strobes", {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk("ho_rvalid0", bus.rvalid0, 1);
    chk("ho_rvalid1", bus.rvalid1, 0);
    chk("ho_rdata0", bus.rdata0, 8'h15);
    @(negedge clk);
    #1;
    chk("ho_gnt1", {bus.gnt1, bus.gnt0}, 2'b10);
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd2; bus.wdata0 = 8'h77;
    @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      #1;
      chk("long_gnt_wr", {bus.gnt0, bus.mem_wr}, 2'b11);
      @(negedge clk);
    end
    bus.req0 = 0;
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd14;
    @(negedge clk);
    #1;
    chk("rs_gnt1", bus.gnt1, 1);
    chk("rs_rd", bus.mem_rd, 1);
    @(posedge clk);
    #1;
    chk("rs_rvalid1", bus.rvalid1, 1);
    chk("rs_rdata1", bus.rdata1, 8'h3C);
    chk("rs_pending_rd", bus.mem_rd, 1);
    #1;
    rst = 0;
    #1;
    chk("rs_gnt1_drop", bus.gnt1, 0);
    chk("rs_rd_drop", bus.mem_rd, 0);
    chk("rs_rvalid1_drop", bus.rvalid1, 0);
    chk("rs_addr_zero", bus.mem_addr, 0);
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.req1 = 1; bus.we1 = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("post_rst_gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
